mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares one external memory interface between NUM_REQ block-fill requesters, e.g. the icache miss path and a prefetcher.
//  Uses round-robin arbitration and owns one transaction at a time: address issue, then collection of BEATS data beats.
//  Each beat is routed to the granted requester. Sits between the miss-handling logic and the memory pins.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  ADDR_W   16  block address width
//  DATA_W   32  memory beat width
//  BEATS    10  beats per block fill (320-bit block / 32-bit beat); >=1
// PORTS
//  clk              in   1               clock, all state on rising edge
//  arst             in   1               reset, asynchronous, active-high
//  i_req_addr       in   NUM_REQ*ADDR_W  requester r address at [r*ADDR_W +: ADDR_W]
//  i_req_valid      in   NUM_REQ         request pending, held until accepted
//  o_req_ready      out  NUM_REQ         one-hot accept pulse
//  o_mem_addr       out  ADDR_W          address to memory
//  o_mem_req_valid  out  1               address valid to memory
//  i_mem_req_ready  in   1               memory accepts address
//  i_mem_data       in   DATA_W          returned beat
//  i_mem_data_valid in   1               beat valid
//  o_rsp_data       out  DATA_W          registered beat to requester
//  o_rsp_valid      out  NUM_REQ         one-hot: beat valid for requester r
//  o_rsp_last       out  1               qualifies final beat of block
//  o_grant          out  NUM_REQ         one-hot owner of current transaction; 0 when idle
//  o_busy           out  1               transaction in flight (state != IDLE)
//  o_spurious       out  1               sticky: beat arrived outside COLLECT
// BEHAVIOUR
//  Reset: state IDLE; ptr=0; beat_cnt=0; all outputs 0.
//   - Async assert aborts any transaction mid-flight; the requester must re-request.
//  FSM IDLE -> ISSUE -> COLLECT -> IDLE.
//  IDLE
//   - If any i_req_valid: winner = first set bit scanning ptr, ptr+1, ... (mod NUM_REQ).
//   - o_req_ready[winner]=1 combinationally in that cycle.
//   - Latch addr and grant; next state ISSUE. No request -> stay IDLE.
//  ISSUE
//   - o_mem_req_valid=1, o_mem_addr = latched addr, held stable until i_mem_req_ready.
//   - On ready: beat_cnt=0 -> COLLECT. Entry to ISSUE comes one cycle after accept.
//  COLLECT
//   - Each i_mem_data_valid: next cycle o_rsp_data = beat, o_rsp_valid = o_grant (1-cycle latency).
//   - beat_cnt increments.
//   - Beat with beat_cnt==BEATS-1: o_rsp_last=1 with that beat's response; state -> IDLE.
//   - Also ptr = (granted index + 1) mod NUM_REQ; o_grant cleared.
//   - Gaps between beats allowed; no timeout.
//  Outputs are 0 whenever not asserted per the rules above.
//  beat_cnt width = $clog2(BEATS) (min 1); never exceeds BEATS-1.
//  Beats arriving in IDLE or ISSUE (incl. same cycle as i_mem_req_ready) are dropped and set o_spurious.
//   - o_spurious clears only on reset.
//  Simultaneous events:
//   - The final-beat cycle never accepts a new request; earliest next accept is the following cycle (one bubble).
//   - Requests changing while not in IDLE have no effect.
//   - A requester deasserting before accept is never granted.
//  No starvation: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1.
// TESTING
//  Single req: r0 addr 0x1234, ready 2 cycles after issue, 10 beats 0..9.
//   -> o_rsp_valid=01 x10, data 0..9, last on 10th, o_grant 0 after.
//  Both valid from reset: addr A=0x0010, B=0x0020.
//   -> grant r0 (A) then r1 (B), then r0 again if still valid.
//  Gapped beats: 3 idle cycles between each beat.
//   -> exactly 10 responses, beat_cnt holds through gaps.
//  Spurious: beat 0xDEADBEEF while IDLE.
//   -> no o_rsp_valid, o_spurious=1 and stays 1.
//  Reset mid-COLLECT after beat 4.
//   -> all outputs 0 immediately, IDLE, ptr=0; re-request completes normally.
//  Stall: i_mem_req_ready low 20 cycles.
//   -> o_mem_addr/o_mem_req_valid stable, no o_req_ready pulses.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that owns one block-fill transaction at a time on a shared memory port.
// It issues the address, collects BEATS data beats and routes each registered beat to the owner.
module mem_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 10
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic                      o_mem_req_valid,
  input  logic                      i_mem_req_ready,
  input  logic [DATA_W-1:0]         i_mem_data,
  input  logic                      i_mem_data_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic                      o_rsp_last,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_spurious
);

  // state   | meaning
  // IDLE    | no transaction; arbitrate and accept one request
  // ISSUE   | address presented to memory until accepted
  // COLLECT | receiving BEATS beats, each forwarded to the owner

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_COLLECT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       grant_idx_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BW-1:0]       beat_cnt_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                rsp_last_q;
  logic                spurious_q;

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand;
  logic                accept;
  logic                last_beat;
  logic                collect_beat;

  // Scan starts at ptr so the requester after the last owner has top priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    o_req_ready     = '0;
    o_mem_req_valid = 1'b0;
    o_mem_addr      = '0;
    accept          = 1'b0;
    last_beat       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          o_req_ready[win_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mem_req_valid = 1'b1;
        o_mem_addr      = addr_q;
        if (i_mem_req_ready) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (i_mem_data_valid && beat_cnt_q == LAST_BEAT) begin
          last_beat = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign collect_beat = (state_q == S_COLLECT) && i_mem_data_valid;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      beat_cnt_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= i_req_addr[win_idx*ADDR_W +: ADDR_W];
        grant_q     <= o_req_ready;
        grant_idx_q <= win_idx;
      end
      if (state_q == S_ISSUE && i_mem_req_ready) beat_cnt_q <= '0;
      if (collect_beat) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
      rsp_data_q  <= collect_beat ? i_mem_data : '0;
      rsp_valid_q <= collect_beat ? grant_q : '0;
      rsp_last_q  <= last_beat;
      if (last_beat) begin
        grant_q <= '0;
        ptr_q   <= (grant_idx_q == LAST_REQ) ? '0 : grant_idx_q + 1'b1;
      end
      // Beats outside COLLECT have no owner; they are dropped but remembered.
      if (i_mem_data_valid && state_q != S_COLLECT) spurious_q <= 1'b1;
    end
  end

  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_last  = rsp_last_q;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_spurious  = spurious_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: arbitration order, beat routing, gaps, stalls,
// spurious beats and reset in the middle of a fill.
module tb_mem_req_arbiter;

  logic        clk;
  logic        arst;
  logic [31:0] i_req_addr;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [15:0] o_mem_addr;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] i_mem_data;
  logic        i_mem_data_valid;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_valid;
  logic        o_rsp_last;
  logic [1:0]  o_grant;
  logic        o_busy;
  logic        o_spurious;

  int n_checks = 0;
  int n_errors = 0;

  mem_req_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32), .BEATS(10)) dut (
    .clk              (clk),
    .arst             (arst),
    .i_req_addr       (i_req_addr),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .o_mem_addr       (o_mem_addr),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .i_mem_data       (i_mem_data),
    .i_mem_data_valid (i_mem_data_valid),
    .o_rsp_data       (o_rsp_data),
    .o_rsp_valid      (o_rsp_valid),
    .o_rsp_last       (o_rsp_last),
    .o_grant          (o_grant),
    .o_busy           (o_busy),
    .o_spurious       (o_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One full fill for requester r; caller has set up any other pending requests.
  task automatic run_txn(input int r, input logic [15:0] addr, input int rdy_dly,
                         input int gap, input logic [31:0] base, input bit hold,
                         input bit pulse_other);
    logic [1:0] onehot;
    onehot = 2'b01 << r;
    i_req_addr[r*16 +: 16] = addr;
    i_req_valid[r] = 1'b1;
    #1;
    chk("req_ready", 64'(o_req_ready), 64'(onehot));
    tick;
    if (!hold) i_req_valid[r] = 1'b0;
    if (pulse_other) i_req_valid[1-r] = 1'b1;
    #1;
    chk("grant", 64'(o_grant), 64'(onehot));
    chk("busy", 64'(o_busy), 64'd1);
    chk("mem_req_valid", 64'(o_mem_req_valid), 64'd1);
    chk("mem_addr", 64'(o_mem_addr), 64'(addr));
    chk("no_accept_issue", 64'(o_req_ready), 64'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      tick;
      chk("stall_valid", 64'(o_mem_req_valid), 64'd1);
      chk("stall_addr", 64'(o_mem_addr), 64'(addr));
      chk("stall_no_ready", 64'(o_req_ready), 64'd0);
    end
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    if (pulse_other) i_req_valid[1-r] = 1'b0;
    for (int b = 0; b < 10; b++) begin
      i_mem_data_valid = 1'b1;
      i_mem_data = base + 32'(b);
      #1;
      chk("no_accept_collect", 64'(o_req_ready), 64'd0);
      tick;
      i_mem_data_valid = 1'b0;
      i_mem_data = '0;
      #1;
      chk("rsp_valid", 64'(o_rsp_valid), 64'(onehot));
      chk("rsp_data", 64'(o_rsp_data), 64'(base + 32'(b)));
      chk("rsp_last", 64'(o_rsp_last), (b == 9) ? 64'd1 : 64'd0);
      if (b < 9) begin
        for (int g = 0; g < gap; g++) begin
          tick;
          chk("gap_rsp_valid", 64'(o_rsp_valid), 64'd0);
          chk("gap_grant", 64'(o_grant), 64'(onehot));
        end
      end
    end
    chk("grant_cleared", 64'(o_grant), 64'd0);
    chk("idle_after", 64'(o_busy), 64'd0);
  endtask

  initial begin
    arst = 1'b1;
    i_req_addr = '0;
    i_req_valid = '0;
    i_mem_req_ready = 1'b0;
    i_mem_data = '0;
    i_mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_mem_valid", 64'(o_mem_req_valid), 64'd0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_spurious", 64'(o_spurious), 64'd0);
    arst = 1'b0;
    tick;

    // Both valid from reset: r0 first (held), then r1, then r0 again.
    i_req_addr = {16'h0020, 16'h0010};
    i_req_valid = 2'b11;
    run_txn(0, 16'h0010, 0, 0, 32'h100, 1'b1, 1'b0);
    run_txn(1, 16'h0020, 0, 0, 32'h200, 1'b0, 1'b0);
    run_txn(0, 16'h0010, 1, 0, 32'h300, 1'b0, 1'b0);

    // Single requester, memory ready two cycles after issue.
    run_txn(0, 16'h1234, 2, 0, 32'h0, 1'b0, 1'b0);
    chk("no_spurious_yet", 64'(o_spurious), 64'd0);

    // Beat while idle.
    i_mem_data_valid = 1'b1;
    i_mem_data = 32'hDEADBEEF;
    tick;
    i_mem_data_valid = 1'b0;
    i_mem_data = '0;
    #1;
    chk("spur_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("spur_rsp_data", 64'(o_rsp_data), 64'd0);
    chk("spur_set", 64'(o_spurious), 64'd1);
    chk("spur_busy", 64'(o_busy), 64'd0);

    // Three idle cycles between beats.
    run_txn(1, 16'h0ABC, 0, 3, 32'hA0, 1'b0, 1'b0);
    chk("spur_sticky", 64'(o_spurious), 64'd1);

    // Long address stall while r1 briefly requests and withdraws.
    run_txn(0, 16'h5555, 20, 0, 32'h5000, 1'b0, 1'b1);
    tick;
    chk("withdrawn_no_ready", 64'(o_req_ready), 64'd0);
    chk("withdrawn_no_busy", 64'(o_busy), 64'd0);
    chk("withdrawn_no_grant", 64'(o_grant), 64'd0);

    // Reset after beat 4 of an r1 fill; ptr is 1 beforehand.
    i_req_addr[31:16] = 16'h0777;
    i_req_valid = 2'b10;
    #1;
    chk("mid_req_ready", 64'(o_req_ready), 64'b10);
    tick;
    i_req_valid = 2'b00;
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      i_mem_data_valid = 1'b1;
      i_mem_data = 32'h70 + 32'(b);
      tick;
      i_mem_data_valid = 1'b0;
      i_mem_data = '0;
    end
    chk("mid_beat4", 64'(o_rsp_data), 64'h74);
    arst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("mid_rst_rsp_data", 64'(o_rsp_data), 64'd0);
    chk("mid_rst_grant", 64'(o_grant), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_spurious", 64'(o_spurious), 64'd0);
    tick;
    arst = 1'b0;
    i_req_addr = {16'h0777, 16'h0F0F};
    i_req_valid = 2'b11;
    #1;
    chk("ptr_reset", 64'(o_req_ready), 64'b01);
    run_txn(0, 16'h0F0F, 1, 0, 32'h900, 1'b0, 1'b0);
    run_txn(1, 16'h0777, 0, 1, 32'hB00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
